// File: rtl/vgafb_scangen_if.sv
`default_nettype none
// ============================================================================
//  Module : vgafb_scangen_if
//  Purpose: Bundles the pixel-feed handshake and the sys->vga FIFO write port
//           used by the vgafb scan generator.
//  Signals:
//    pix_valid  - pixel feed has a word available
//    pix_data   - pixel word (format selected by the scan generator mode)
//    pix_ack    - scan generator consumes pix_data this cycle
//    fifo_full  - FIFO almost-full (one free slot still guaranteed)
//    fifo_we    - FIFO write strobe
//    fifo_data  - {vsync_n, hsync_n, r[7:0], g[7:0], b[7:0]}
//  Modports:
//    master - the scan generator (drives ack and the FIFO write port)
//    slave  - the surrounding pixel source / FIFO
//  Revision: 1.0 - initial release
// ============================================================================
interface vgafb_scangen_if;
  logic        pix_valid;
  logic [31:0] pix_data;
  logic        pix_ack;
  logic        fifo_full;
  logic        fifo_we;
  logic [25:0] fifo_data;

  modport master (
    input  pix_valid, pix_data, fifo_full,
    output pix_ack, fifo_we, fifo_data
  );

  modport slave (
    output pix_valid, pix_data, fifo_full,
    input  pix_ack, fifo_we, fifo_data
  );
endinterface
`default_nettype wire

// File: rtl/vgafb_scangen.sv
`default_nettype none
// ============================================================================
//  Module : vgafb_scangen
//  Purpose: Raster scan generator for the vgafb framebuffer. Runs the h/v
//           counters in the system clock, pulls pixels from the pixel feed
//           and writes {vsync_n, hsync_n, RGB888} words into the sys->vga
//           clock-crossing FIFO.
//  Ports:
//    sys_clk, sys_rst          - clock, synchronous active-high reset
//    enable                    - run request; dropping it stops at end of frame
//    hres..hscan, vres..vscan  - raster timing (pixels / lines, last index)
//    hsync_pol, vsync_pol      - 1 = active-high sync at the pads
//    mode                      - 0 RGB565, 1 RGB888, 2 gray8, 3 black
//    hdouble                   - emit every source pixel twice
//    bus                       - pixel feed + FIFO write port (master side)
//    frame_start               - pulse alongside the word at h=0, v=0
//    running                   - generator is not idle
//    underrun_clr              - clears underrun_count
//    underrun_count            - saturating count of active feed stalls
//  Revision: 1.0 - initial release
// ============================================================================
module vgafb_scangen #(
  parameter int TW  = 12,
  parameter int UCW = 16
) (
  input  wire logic           sys_clk,
  input  wire logic           sys_rst,
  input  wire logic           enable,
  input  wire logic [TW-1:0]  hres,
  input  wire logic [TW-1:0]  hsync_start,
  input  wire logic [TW-1:0]  hsync_end,
  input  wire logic [TW-1:0]  hscan,
  input  wire logic [TW-1:0]  vres,
  input  wire logic [TW-1:0]  vsync_start,
  input  wire logic [TW-1:0]  vsync_end,
  input  wire logic [TW-1:0]  vscan,
  input  wire logic           hsync_pol,
  input  wire logic           vsync_pol,
  input  wire logic [1:0]     mode,
  input  wire logic           hdouble,
  vgafb_scangen_if.master     bus,
  output logic                frame_start,
  output logic                running,
  input  wire logic           underrun_clr,
  output logic [UCW-1:0]      underrun_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic [TW-1:0]  TW_ONE  = TW'(1);
  localparam logic [UCW-1:0] UCW_ONE = UCW'(1);

  logic [1:0]     state_q, state_d;
  logic [TW-1:0]  h_q, h_d;
  logic [TW-1:0]  v_q, v_d;
  logic           phase_q, phase_d;
  logic           fifo_we_q, fifo_we_d;
  logic [25:0]    fifo_data_q, fifo_data_d;
  logic           frame_start_q, frame_start_d;
  logic [UCW-1:0] underrun_q, underrun_d;

  logic           live;
  logic           active;
  logic           step;
  logic           at_frame_end;
  logic           hs_act, vs_act;
  logic [23:0]    rgb;
  logic           stall;

  // Upper byte of the pixel word is never used by any supported format.
  logic           unused_pix_hi;
  assign unused_pix_hi = ^bus.pix_data[31:24];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. A stop request only takes effect once the last word of
  // the frame has been stepped, so the display never sees a truncated frame.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_STOP;
      ST_STOP: begin
        if (enable)                    state_d = ST_RUN;
        else if (step && at_frame_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    live    = (state_q != ST_IDLE);
    running = live;
  end

  // --------------------------------------------------------------------------
  // Raster datapath
  // --------------------------------------------------------------------------
  always_comb begin
    active       = (h_q < hres) && (v_q < vres);
    at_frame_end = (h_q == hscan) && (v_q == vscan);
    // Blanking never waits for the feed; only the FIFO can hold it back.
    step         = live && !bus.fifo_full && (!active || bus.pix_valid);
    // With doubling, the source pixel is consumed on its second emission.
    bus.pix_ack  = step && active && (!hdouble || phase_q);
    stall        = live && !bus.fifo_full && active && !bus.pix_valid;

    // An empty window (start >= end) naturally never asserts.
    hs_act = (h_q >= hsync_start) && (h_q < hsync_end);
    vs_act = (v_q >= vsync_start) && (v_q < vsync_end);
  end

  always_comb begin
    rgb = 24'h0;
    if (active) begin
      case (mode)
        2'd0: rgb = {bus.pix_data[15:11], bus.pix_data[15:13],
                     bus.pix_data[10:5],  bus.pix_data[10:9],
                     bus.pix_data[4:0],   bus.pix_data[4:2]};
        2'd1: rgb = bus.pix_data[23:0];
        2'd2: rgb = {3{bus.pix_data[7:0]}};
        default: rgb = 24'h0;
      endcase
    end
  end

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    phase_d = phase_q;

    if (!live) begin
      h_d     = '0;
      v_d     = '0;
      phase_d = 1'b0;
    end else begin
      if (step) begin
        if (h_q == hscan) begin
          h_d = '0;
          v_d = (v_q == vscan) ? '0 : v_q + TW_ONE;
        end else begin
          h_d = h_q + TW_ONE;
        end
      end
      // Phase restarts at every blanking interval, so an odd hres simply
      // leaves the last source pixel of the line un-acked.
      if (!active)   phase_d = 1'b0;
      else if (step) phase_d = ~phase_q;
    end

    fifo_we_d     = step;
    fifo_data_d   = step ? {vs_act ^ !vsync_pol, hs_act ^ !hsync_pol, rgb} : fifo_data_q;
    frame_start_d = step && (h_q == '0) && (v_q == '0);

    underrun_d = underrun_q;
    if (underrun_clr)                      underrun_d = '0;
    else if (stall && (underrun_q != '1))  underrun_d = underrun_q + UCW_ONE;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      h_q           <= '0;
      v_q           <= '0;
      phase_q       <= 1'b0;
      fifo_we_q     <= 1'b0;
      fifo_data_q   <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      phase_q       <= phase_d;
      fifo_we_q     <= fifo_we_d;
      fifo_data_q   <= fifo_data_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign bus.fifo_we    = fifo_we_q;
  assign bus.fifo_data  = fifo_data_q;
  assign frame_start    = frame_start_q;
  assign underrun_count = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_vgafb_scangen.sv
`default_nettype none
// ============================================================================
//  Module : tb_vgafb_scangen
//  Purpose: Directed self-checking bench for vgafb_scangen on a small 8x4
//           raster (4x2 visible). A second instance with a 2-bit underrun
//           counter shares all stimulus.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_vgafb_scangen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] hres = 12'd4, hsync_start = 12'd5, hsync_end = 12'd6, hscan = 12'd7;
  logic [11:0] vres = 12'd2, vsync_start = 12'd2, vsync_end = 12'd3, vscan = 12'd3;
  logic        hsync_pol = 1'b0, vsync_pol = 1'b0;
  logic [1:0]  mode = 2'd1;
  logic        hdouble = 1'b0;
  logic        pix_valid_r = 1'b1;
  logic        fifo_full_r = 1'b0;
  logic [31:0] pix_base = 32'h0012_3456;
  logic        feed_inc = 1'b0;
  logic [23:0] src_cnt = 24'h000010;
  logic        underrun_clr = 1'b0;

  logic        frame_start, running;
  logic [15:0] underrun_count;
  logic        frame_start2, running2;
  logic [1:0]  underrun_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vgafb_scangen_if bus ();
  vgafb_scangen_if bus2 ();

  assign bus.pix_valid  = pix_valid_r;
  assign bus.pix_data   = feed_inc ? {8'h00, src_cnt} : pix_base;
  assign bus.fifo_full  = fifo_full_r;
  assign bus2.pix_valid = pix_valid_r;
  assign bus2.pix_data  = feed_inc ? {8'h00, src_cnt} : pix_base;
  assign bus2.fifo_full = fifo_full_r;

  vgafb_scangen #(.TW(12), .UCW(16)) dut (
    .sys_clk(clk), .sys_rst(rst), .enable(enable),
    .hres(hres), .hsync_start(hsync_start), .hsync_end(hsync_end), .hscan(hscan),
    .vres(vres), .vsync_start(vsync_start), .vsync_end(vsync_end), .vscan(vscan),
    .hsync_pol(hsync_pol), .vsync_pol(vsync_pol), .mode(mode), .hdouble(hdouble),
    .bus(bus), .frame_start(frame_start), .running(running),
    .underrun_clr(underrun_clr), .underrun_count(underrun_count)
  );

  vgafb_scangen #(.TW(12), .UCW(2)) dut_sat (
    .sys_clk(clk), .sys_rst(rst), .enable(enable),
    .hres(hres), .hsync_start(hsync_start), .hsync_end(hsync_end), .hscan(hscan),
    .vres(vres), .vsync_start(vsync_start), .vsync_end(vsync_end), .vscan(vscan),
    .hsync_pol(hsync_pol), .vsync_pol(vsync_pol), .mode(mode), .hdouble(hdouble),
    .bus(bus2), .frame_start(frame_start2), .running(running2),
    .underrun_clr(underrun_clr), .underrun_count(underrun_count2)
  );

  // Write/ack monitor, sampled on the falling edge.
  int          n_we, n_ack, n_fs;
  logic [25:0] wlog [0:127];
  logic        fslog [0:127];
  logic        mon_clr = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_we = 0; n_ack = 0; n_fs = 0;
    end else begin
      if (bus.pix_ack) n_ack++;
      if (bus.fifo_we) begin
        if (n_we < 128) begin
          wlog[n_we]  = bus.fifo_data;
          fslog[n_we] = frame_start;
        end
        n_we++;
        if (frame_start) n_fs++;
      end
    end
  end

  // Incrementing pixel source: advances just after each consuming edge.
  always begin
    @(negedge clk);
    if (feed_inc && bus.pix_ack) begin
      @(posedge clk);
      #1;
      src_cnt = src_cnt + 24'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (running && k < 500) begin
      tick();
      k++;
    end
    check_eq(tag, running, 0);
    tick();
    tick();
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic run_frame(input string tag);
    clear_mon();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_idle(tag);
  endtask

  task automatic wait_writes(input int target, input string tag);
    int k;
    k = 0;
    while (n_we < target && k < 500) begin
      tick();
      k++;
    end
    check_eq(tag, n_we >= target, 1);
  endtask

  // Expected word on the test raster with active-low syncs.
  function automatic logic [25:0] exp_word(input int i, input logic [23:0] rgb_act);
    int  h, v;
    logic act;
    h   = i % 8;
    v   = (i % 32) / 8;
    act = (h < 4) && (v < 2);
    return {(v == 2) ? 1'b0 : 1'b1, (h == 5) ? 1'b0 : 1'b1, act ? rgb_act : 24'h0};
  endfunction

  initial begin
    int k0, fs_ok;

    // Reset state
    tick(); tick();
    check_eq("rst_running", running, 0);
    check_eq("rst_we", bus.fifo_we, 0);
    check_eq("rst_data", bus.fifo_data, 0);
    check_eq("rst_ack", bus.pix_ack, 0);
    check_eq("rst_uc", underrun_count, 0);
    rst = 1'b0;
    tick();

    // Two frames, enable dropped at h=2,v=1 of the second: clean finish
    clear_mon();
    enable = 1'b1;
    wait_writes(42, "t2_wait");
    enable = 1'b0;
    wait_idle("t2_idle");
    check_eq("t2_writes", n_we, 64);
    check_eq("t2_acks", n_ack, 16);
    check_eq("t2_fs_cnt", n_fs, 2);
    fs_ok = (fslog[0] === 1'b1 && fslog[32] === 1'b1) ? 1 : 0;
    check_eq("t2_fs_pos", fs_ok, 1);
    for (int i = 0; i < 32; i++)
      check_eq($sformatf("t2_word%0d", i), wlog[i], exp_word(i, 24'h123456));
    check_eq("t2_word40", wlog[40], exp_word(40, 24'h123456));

    // Pixel formats
    mode = 2'd0; pix_base = 32'h0000_F800;
    run_frame("m0a_idle");
    check_eq("m0_red", wlog[0][23:0], 24'hFF0000);
    check_eq("m0_blank", wlog[4][23:0], 24'h000000);
    pix_base = 32'h0000_8410;
    run_frame("m0b_idle");
    check_eq("m0_mid", wlog[1][23:0], 24'h848284);
    mode = 2'd2; pix_base = 32'hFFFF_FF5A;
    run_frame("m2_idle");
    check_eq("m2_gray", wlog[2][23:0], 24'h5A5A5A);
    mode = 2'd3; pix_base = 32'h0012_3456;
    run_frame("m3_idle");
    check_eq("m3_black", wlog[0][23:0], 24'h000000);
    check_eq("m3_writes", n_we, 32);
    mode = 2'd1;

    // Active-high sync polarity
    hsync_pol = 1'b1; vsync_pol = 1'b1;
    run_frame("pol_idle");
    check_eq("pol_hs_on", wlog[5][24], 1);
    check_eq("pol_hs_off", wlog[4][24], 0);
    check_eq("pol_vs_on", wlog[16][25], 1);
    check_eq("pol_vs_off", wlog[0][25], 0);
    hsync_pol = 1'b0; vsync_pol = 1'b0;

    // Horizontal doubling with an incrementing source
    hdouble = 1'b1; feed_inc = 1'b1;
    run_frame("hd_idle");
    check_eq("hd_acks", n_ack, 4);
    check_eq("hd_writes", n_we, 32);
    check_eq("hd_w0", wlog[0][23:0], 24'h000010);
    check_eq("hd_w1", wlog[1][23:0], 24'h000010);
    check_eq("hd_w2", wlog[2][23:0], 24'h000011);
    check_eq("hd_w3", wlog[3][23:0], 24'h000011);
    check_eq("hd_w8", wlog[8][23:0], 24'h000012);
    check_eq("hd_w11", wlog[11][23:0], 24'h000013);
    hdouble = 1'b0; feed_inc = 1'b0;

    // Five feed stalls at the start of a frame; 2-bit counter saturates
    clear_mon();
    pix_valid_r = 1'b0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check_eq("ur_running", running, 1);
    repeat (5) tick();
    pix_valid_r = 1'b1;
    wait_idle("ur_idle");
    check_eq("ur_count", underrun_count, 5);
    check_eq("ur_sat", underrun_count2, 3);
    check_eq("ur_writes", n_we, 32);

    // Reset mid-line aborts immediately
    clear_mon();
    enable = 1'b1;
    wait_writes(3, "rst_wait");
    rst = 1'b1;
    tick();
    check_eq("mr_running", running, 0);
    check_eq("mr_we", bus.fifo_we, 0);
    check_eq("mr_data", bus.fifo_data, 0);
    check_eq("mr_fs", frame_start, 0);
    check_eq("mr_ack", bus.pix_ack, 0);
    check_eq("mr_uc", underrun_count, 0);
    enable = 1'b0;
    rst = 1'b0;
    tick();

    // Clear wins over a simultaneous stall increment
    underrun_clr = 1'b1;
    pix_valid_r = 1'b0;
    clear_mon();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (3) tick();
    check_eq("clr_hold", underrun_count, 0);
    underrun_clr = 1'b0;
    pix_valid_r = 1'b1;
    wait_idle("clr_idle");
    check_eq("clr_after", underrun_count, 0);

    // FIFO full for five cycles mid-line freezes everything
    clear_mon();
    enable = 1'b1;
    wait_writes(3, "ff_wait");
    fifo_full_r = 1'b1;
    pix_valid_r = 1'b0;
    tick();
    k0 = n_we;
    repeat (4) tick();
    check_eq("ff_no_we", n_we, k0);
    check_eq("ff_no_ur", underrun_count, 0);
    fifo_full_r = 1'b0;
    pix_valid_r = 1'b1;
    tick();
    enable = 1'b0;
    wait_idle("ff_idle");
    check_eq("ff_writes", n_we, 32);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("ff_word%0d", i), wlog[i], exp_word(i, 24'h123456));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
